tlb_entry_pool_v2: RTL and testbench
====================================

Name: tlb_entry_pool_v2

Overview:
- Parametrised successor to the MMU's TLB entry pool. Holds complete TLB entries (header plus even/odd halves) for TLBR readback.
- Serves PFN/flag halves and page masks to the instruction and data lookup paths.
- Adds a ready/valid write handshake with odd-half forwarding, and a hardware flush FSM that zeroes every entry after reset or on request.
- Sits between the CP0 TLB instruction logic (TLBWI/TLBWR/TLBR/TLBINV) and the two CAM match units.

Parameters:
- ENTRIES, 32, number of TLB entries; power of two, 4..64. IDX_W = clog2(ENTRIES).
- HALF_W, 25, width of one entry half: {PFN, C, D, V}.
- HDR_W, 44, width of the header: {PageMask, VPN2, G, ASID}.
- MASK_W, 16, width of the page mask.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready at a clk rising edge.
- wr_index  in  IDX_W  entry to write (Index or Random).
- wr_entry  in  2*HALF_W  {odd half, even half}.
- wr_header  in  HDR_W  entry header.
- wr_mask  in  MASK_W  page mask copy used by the lookups.
- flush_req  in  1  one-cycle pulse: invalidate all entries.
- flush_busy  out  1  flush in progress.
- idx_a  in  IDX_W+1  instruction lookup: {odd select, entry index}.
- entry_a  out  HALF_W  selected half.
- mask_a  out  MASK_W  page mask of the entry.
- idx_b, entry_b, mask_b  same as A, for the data lookup.
- idx_c  in  IDX_W  TLBR index.
- entry_c  out  2*HALF_W  stored entry halves.
- header_c  out  HDR_W  stored header.

Behaviour:
- Storage
  - full pool: ENTRIES x (2*HALF_W+HDR_W).
  - mask pool: ENTRIES x MASK_W.
  - half pool: 2*ENTRIES x HALF_W, addressed {odd, idx}, one write port.
  - No reset on the arrays.
- All read ports are combinational, asynchronous reads.
- FSM states: FLUSH, IDLE, WR2.
- Reset (rst_n low): enter FLUSH with counter = 0 and phase = 0; wr_ready = 0; flush_busy = 1; pending registers cleared. Reset asserted mid-flush or mid-write restarts the flush from index 0.
- FLUSH, phase 0: zero full[cnt], mask[cnt] and half{0,cnt}.
- FLUSH, phase 1: zero half{1,cnt}; then cnt++.
- Flush takes exactly 2*ENTRIES cycles. Afterwards go to IDLE and deassert flush_busy in the same edge.
- IDLE: wr_ready = !flush_req.
  - flush_req high: go to FLUSH. Flush beats a simultaneous wr_valid; that write is not accepted and must be held.
  - Write accepted at edge T: full[wr_index] <= {wr_entry, wr_header}; mask[wr_index] <= wr_mask; half{0,wr_index} <= wr_entry even half. Odd half and index are latched; go to WR2.
- WR2: wr_ready = 0; half{1,idx} <= latched odd half at edge T+1; return to IDLE.
  - flush_req in WR2 is registered. Flush starts after the WR2 commit; it is not lost.
  - Writes are therefore accepted at most every 2 cycles.
- Forwarding: in WR2, a lookup on port A or B with idx == {1, pending idx} returns the latched odd half. All ports are coherent with the new entry from cycle T+1.
- flush_req during FLUSH: ignored.
- wr_valid during FLUSH: not accepted.
- Lookup outputs during FLUSH reflect partially cleared contents. Consumers gate on flush_busy.
- Output reset values: wr_ready = 0, flush_busy = 1. Data outputs reflect array contents, which are zero after the first flush.

Test Plan:
- Release rst_n, ENTRIES = 32 → flush_busy high for exactly 64 cycles, then wr_ready = 1; all entry_c, header_c, mask_a are 0.
- Write idx 5, entry {25'h1ABCD5, 25'h0F00F}, header 44'hA5, mask 16'h00FF → wr_ready low 1 cycle. Next cycle idx_a = {1,5} gives 25'h1ABCD5 via forwarding, idx_b = {0,5} gives 25'h0F00F, mask = 16'h00FF. One cycle later the same values come from the array.
- Back-to-back wr_valid held for 2 writes (idx 3, idx 4) → accepted 2 cycles apart; entry_c/header_c correct for both.
- flush_req and wr_valid in the same IDLE cycle → write not accepted; flush runs 64 cycles; the held write is then accepted and only that entry is nonzero.
- flush_req during WR2 → odd half committed, then 64-cycle flush; entry is zero afterwards.
- rst_n pulsed at flush count 10 → flush restarts from 0 and takes a full 64 cycles after release.

Source files
------------

// File: rtl/tlb_entry_pool_v2.sv
// rtl/tlb_entry_pool_v2.sv - TLB entry pool with ready/valid write, odd-half forwarding and flush FSM
module tlb_entry_pool_v2 #(
    parameter int ENTRIES = 32,
    parameter int HALF_W  = 25,
    parameter int HDR_W   = 44,
    parameter int MASK_W  = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [2*HALF_W-1:0]   wr_entry,
    input  logic [HDR_W-1:0]      wr_header,
    input  logic [MASK_W-1:0]     wr_mask,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic [IDX_W:0]        idx_a,
    output logic [HALF_W-1:0]     entry_a,
    output logic [MASK_W-1:0]     mask_a,
    input  logic [IDX_W:0]        idx_b,
    output logic [HALF_W-1:0]     entry_b,
    output logic [MASK_W-1:0]     mask_b,
    input  logic [IDX_W-1:0]      idx_c,
    output logic [2*HALF_W-1:0]   entry_c,
    output logic [HDR_W-1:0]      header_c
);

    localparam int FULL_W = 2*HALF_W + HDR_W;

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_WR2} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic                phase_q;
    logic                rdy_q;
    logic                busy_q;
    logic [IDX_W-1:0]    pend_idx_q;
    logic [HALF_W-1:0]   pend_odd_q;

    logic [FULL_W-1:0]   full_mem [ENTRIES];
    logic [MASK_W-1:0]   mask_mem [ENTRIES];
    logic [HALF_W-1:0]   half_mem [2*ENTRIES];

    logic                full_we;
    logic [IDX_W-1:0]    full_waddr;
    logic [FULL_W-1:0]   full_wdata;
    logic [MASK_W-1:0]   mask_wdata;
    logic                half_we;
    logic [IDX_W:0]      half_waddr;
    logic [HALF_W-1:0]   half_wdata;
    logic                wr_fire;

    // wr_ready drops combinationally with flush_req so a flush always wins over a write.
    assign wr_ready   = rdy_q & ~flush_req;
    assign flush_busy = busy_q;
    assign wr_fire    = wr_valid & wr_ready;

    always_comb begin
        full_we    = 1'b0;
        full_waddr = wr_index;
        full_wdata = {wr_entry, wr_header};
        mask_wdata = wr_mask;
        half_we    = 1'b0;
        half_waddr = {1'b0, wr_index};
        half_wdata = wr_entry[HALF_W-1:0];
        case (state_q)
            S_FLUSH: begin
                half_we    = 1'b1;
                half_wdata = '0;
                if (!phase_q) begin
                    full_we    = 1'b1;
                    full_waddr = cnt_q;
                    full_wdata = '0;
                    mask_wdata = '0;
                    half_waddr = {1'b0, cnt_q};
                end else begin
                    half_waddr = {1'b1, cnt_q};
                end
            end
            S_IDLE: begin
                full_we = wr_fire;
                half_we = wr_fire;
            end
            S_WR2: begin
                half_we    = 1'b1;
                half_waddr = {1'b1, pend_idx_q};
                half_wdata = pend_odd_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (full_we) begin
            full_mem[full_waddr] <= full_wdata;
            mask_mem[full_waddr] <= mask_wdata;
        end
        if (half_we) begin
            half_mem[half_waddr] <= half_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FLUSH;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b1;
            pend_idx_q <= '0;
            pend_odd_q <= '0;
        end else begin
            case (state_q)
                S_FLUSH: begin
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == IDX_W'(ENTRIES-1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (flush_req) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= '0;
                        phase_q <= 1'b0;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end else if (wr_valid) begin
                        state_q    <= S_WR2;
                        rdy_q      <= 1'b0;
                        pend_idx_q <= wr_index;
                        pend_odd_q <= wr_entry[2*HALF_W-1:HALF_W];
                    end
                end
                S_WR2: begin
                    // The odd half commits this edge regardless; a flush seen here starts right after.
                    if (flush_req) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= '0;
                        phase_q <= 1'b0;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_FLUSH;
                    cnt_q   <= '0;
                    phase_q <= 1'b0;
                    busy_q  <= 1'b1;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        entry_a = half_mem[idx_a];
        if (state_q == S_WR2 && idx_a == {1'b1, pend_idx_q}) begin
            entry_a = pend_odd_q;
        end
        entry_b = half_mem[idx_b];
        if (state_q == S_WR2 && idx_b == {1'b1, pend_idx_q}) begin
            entry_b = pend_odd_q;
        end
    end

    assign mask_a   = mask_mem[idx_a[IDX_W-1:0]];
    assign mask_b   = mask_mem[idx_b[IDX_W-1:0]];
    assign entry_c  = full_mem[idx_c][FULL_W-1:HDR_W];
    assign header_c = full_mem[idx_c][HDR_W-1:0];

endmodule

// File: tb/tb_tlb_entry_pool_v2.sv
// tb/tb_tlb_entry_pool_v2.sv - scoreboard bench for tlb_entry_pool_v2
module tb_tlb_entry_pool_v2;

    localparam int ENTRIES = 32;
    localparam int IDX_W   = 5;
    localparam int HALF_W  = 25;
    localparam int HDR_W   = 44;
    localparam int MASK_W  = 16;

    logic                clk;
    logic                rst_n;
    logic                wr_valid;
    logic                wr_ready;
    logic [IDX_W-1:0]    wr_index;
    logic [2*HALF_W-1:0] wr_entry;
    logic [HDR_W-1:0]    wr_header;
    logic [MASK_W-1:0]   wr_mask;
    logic                flush_req;
    logic                flush_busy;
    logic [IDX_W:0]      idx_a;
    logic [HALF_W-1:0]   entry_a;
    logic [MASK_W-1:0]   mask_a;
    logic [IDX_W:0]      idx_b;
    logic [HALF_W-1:0]   entry_b;
    logic [MASK_W-1:0]   mask_b;
    logic [IDX_W-1:0]    idx_c;
    logic [2*HALF_W-1:0] entry_c;
    logic [HDR_W-1:0]    header_c;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [HALF_W-1:0] odd;
        logic [HALF_W-1:0] even;
        logic [HDR_W-1:0]  hdr;
        logic [MASK_W-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int checks;
    int failures;
    int cyc;

    tlb_entry_pool_v2 #(.ENTRIES(ENTRIES), .HALF_W(HALF_W), .HDR_W(HDR_W), .MASK_W(MASK_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
        .wr_entry(wr_entry), .wr_header(wr_header), .wr_mask(wr_mask),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .idx_a(idx_a), .entry_a(entry_a), .mask_a(mask_a),
        .idx_b(idx_b), .entry_b(entry_b), .mask_b(mask_b),
        .idx_c(idx_c), .entry_c(entry_c), .header_c(header_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_flush(input string name);
        int n;
        n = 0;
        while (flush_busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 64) begin
            failures++;
            $display("FAIL %s flush_cycles actual=%0d expected=64", name, n);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_after_flush actual=%b expected=1", name, wr_ready);
        end
    endtask

    task automatic send_write(input exp_t e, input bit hold, output int acc_cyc);
        int n;
        sb.push_back(e);
        wr_valid  = 1'b1;
        wr_index  = e.idx;
        wr_entry  = {e.odd, e.even};
        wr_header = e.hdr;
        wr_mask   = e.mask;
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL write_timeout idx=%0d actual_ready=%b expected=1", e.idx, wr_ready);
        end
        step();
        acc_cyc = cyc;
        if (!hold) wr_valid = 1'b0;
    endtask

    task automatic check_pop_entry(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard_empty actual=0 expected>0", name);
        end else begin
            e = sb.pop_front();
            idx_c = e.idx;
            idx_a = {1'b1, e.idx};
            idx_b = {1'b0, e.idx};
            #1;
            checks++;
            if (entry_c !== {e.odd, e.even}) begin
                failures++;
                $display("FAIL %s entry_c idx=%0d actual=%h expected=%h", name, e.idx, entry_c, {e.odd, e.even});
            end
            checks++;
            if (header_c !== e.hdr) begin
                failures++;
                $display("FAIL %s header_c idx=%0d actual=%h expected=%h", name, e.idx, header_c, e.hdr);
            end
            checks++;
            if (entry_a !== e.odd) begin
                failures++;
                $display("FAIL %s entry_a_odd idx=%0d actual=%h expected=%h", name, e.idx, entry_a, e.odd);
            end
            checks++;
            if (entry_b !== e.even) begin
                failures++;
                $display("FAIL %s entry_b_even idx=%0d actual=%h expected=%h", name, e.idx, entry_b, e.even);
            end
            checks++;
            if (mask_a !== e.mask || mask_b !== e.mask) begin
                failures++;
                $display("FAIL %s mask idx=%0d actual=%h/%h expected=%h", name, e.idx, mask_a, mask_b, e.mask);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0; flush_req = 1'b0;
        wr_index = '0; wr_entry = '0; wr_header = '0; wr_mask = '0;
        idx_a = '0; idx_b = '0; idx_c = '0;
        repeat (3) step();
        checks++;
        if (wr_ready !== 1'b0 || flush_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs actual=ready%b/busy%b expected=ready0/busy1", wr_ready, flush_busy);
        end
        rst_n = 1'b1;
        count_flush("reset");
        for (int i = 0; i < ENTRIES; i++) begin
            idx_c = i[IDX_W-1:0];
            idx_a = {1'b0, i[IDX_W-1:0]};
            #1;
            checks++;
            if (entry_c !== '0 || header_c !== '0 || mask_a !== '0) begin
                failures++;
                $display("FAIL reset_clear idx=%0d actual=%h/%h/%h expected=0", i, entry_c, header_c, mask_a);
            end
        end
    endtask

    task automatic test_write();
        exp_t e;
        e = '{idx: 5'd5, odd: 25'h1ABCD5, even: 25'h0F00F, hdr: 44'hA5, mask: 16'h00FF};
        sb.push_back(e);
        wr_valid = 1'b1; wr_index = e.idx; wr_entry = {e.odd, e.even};
        wr_header = e.hdr; wr_mask = e.mask;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_ready_idle actual=%b expected=1", wr_ready);
        end
        step();
        wr_valid = 1'b0;
        idx_a = {1'b1, 5'd5};
        idx_b = {1'b0, 5'd5};
        idx_c = 5'd5;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_ready_wr2 actual=%b expected=0", wr_ready);
        end
        checks++;
        if (entry_a !== 25'h1ABCD5) begin
            failures++;
            $display("FAIL forward_odd actual=%h expected=%h", entry_a, 25'h1ABCD5);
        end
        checks++;
        if (entry_b !== 25'h0F00F || mask_a !== 16'h00FF) begin
            failures++;
            $display("FAIL wr2_even_mask actual=%h/%h expected=%h/%h", entry_b, mask_a, 25'h0F00F, 16'h00FF);
        end
        checks++;
        if (entry_c !== {25'h1ABCD5, 25'h0F00F} || header_c !== 44'hA5) begin
            failures++;
            $display("FAIL wr2_full actual=%h/%h expected=%h/%h", entry_c, header_c, {25'h1ABCD5, 25'h0F00F}, 44'hA5);
        end
        step();
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_ready_after actual=%b expected=1", wr_ready);
        end
        check_pop_entry("write_array");
    endtask

    task automatic test_back_to_back();
        exp_t e3, e4;
        int c1, c2;
        e3 = '{idx: 5'd3, odd: 25'h1234567, even: 25'h0765432, hdr: 44'hABC_DEF0_1234, mask: 16'h0F0F};
        e4 = '{idx: 5'd4, odd: 25'h0AAAAAA, even: 25'h1555555, hdr: 44'h123_4567_89AB, mask: 16'hF00F};
        send_write(e3, 1'b1, c1);
        send_write(e4, 1'b0, c2);
        checks++;
        if (c2 - c1 !== 2) begin
            failures++;
            $display("FAIL back_to_back_spacing actual=%0d expected=2", c2 - c1);
        end
        step();
        check_pop_entry("b2b_first");
        check_pop_entry("b2b_second");
    endtask

    task automatic test_flush_vs_write();
        exp_t e;
        int c;
        e = '{idx: 5'd7, odd: 25'h1FEDCBA, even: 25'h0012345, hdr: 44'hFFF_0000_FFFF, mask: 16'h3C3C};
        sb.push_back(e);
        wr_valid = 1'b1; wr_index = e.idx; wr_entry = {e.odd, e.even};
        wr_header = e.hdr; wr_mask = e.mask;
        flush_req = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_beats_write_ready actual=%b expected=0", wr_ready);
        end
        step();
        flush_req = 1'b0;
        checks++;
        if (flush_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_vs_write_busy actual=%b expected=1", flush_busy);
        end
        count_flush("flush_vs_write");
        step();
        c = cyc;
        wr_valid = 1'b0;
        step();
        for (int i = 0; i < ENTRIES; i++) begin
            idx_c = i[IDX_W-1:0];
            #1;
            checks++;
            if (entry_c !== ((i == 7) ? {e.odd, e.even} : '0)) begin
                failures++;
                $display("FAIL only_held_entry idx=%0d actual=%h expected=%h", i, entry_c,
                         (i == 7) ? {e.odd, e.even} : 50'h0);
            end
        end
        check_pop_entry("held_write");
    endtask

    task automatic test_flush_in_wr2();
        exp_t e;
        int c;
        e = '{idx: 5'd9, odd: 25'h1C0FFEE, even: 25'h0BEEF00, hdr: 44'h5A5_A5A5_A5A5, mask: 16'h8001};
        send_write(e, 1'b0, c);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        idx_a = {1'b1, 5'd9};
        #1;
        checks++;
        if (flush_busy !== 1'b1 || entry_a !== e.odd) begin
            failures++;
            $display("FAIL wr2_flush_commit actual=busy%b/%h expected=busy1/%h", flush_busy, entry_a, e.odd);
        end
        void'(sb.pop_front());
        count_flush("flush_in_wr2");
        idx_c = 5'd9;
        #1;
        checks++;
        if (entry_c !== '0 || entry_a !== '0) begin
            failures++;
            $display("FAIL wr2_flush_cleared actual=%h/%h expected=0/0", entry_c, entry_a);
        end
    endtask

    task automatic test_reset_mid_flush();
        exp_t e;
        int c;
        e = '{idx: 5'd20, odd: 25'h0111111, even: 25'h0222222, hdr: 44'h333, mask: 16'h4444};
        send_write(e, 1'b0, c);
        step();
        void'(sb.pop_front());
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (20) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (flush_busy !== 1'b1 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_flush_reset_outputs actual=busy%b/ready%b expected=busy1/ready0", flush_busy, wr_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        count_flush("reset_mid_flush");
        idx_c = 5'd20;
        idx_a = {1'b1, 5'd20};
        #1;
        checks++;
        if (entry_c !== '0 || entry_a !== '0 || mask_a !== '0) begin
            failures++;
            $display("FAIL mid_flush_cleared actual=%h/%h/%h expected=0", entry_c, entry_a, mask_a);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        test_reset();
        test_write();
        test_back_to_back();
        test_flush_vs_write();
        test_flush_in_wr2();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
